vco_meas_sequencer: RTL

//  Digital controller for the two on-chip ring VCOs. It releases each VCO from reset, waits a settle

---
 rtl/vco_meas_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/vco_meas_sequencer.sv
// Ring-VCO measurement sequencer: releases one VCO at a time, waits a settle time, then counts its
// synchronized rising edges over a gate window. Optional macro VCO_MEAS_CONT_EN adds the cont input.
module vco_meas_sequencer #(
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef VCO_MEAS_CONT_EN
    input  logic              cont,
`endif
    input  logic [1:0]        mode,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              vco1_in,
    input  logic              vco2_in,
    output logic              vco1_rst,
    output logic              vco2_rst,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  result,
    output logic              result_sel,
    output logic              overflow
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [1:0] MODE_VCO2 = 2'd1;
    localparam logic [1:0] MODE_PAIR = 2'd2;

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_t;

    state_t            state, state_nxt;
    logic [1:0]        mode_q;
    logic [GATE_W-1:0] gate_q;
    logic              sel;
    logic [TMR_W-1:0]  tmr;
    logic [CNT_W-1:0]  count, count_nxt;
    logic              ovf, ovf_nxt;
    logic [2:0]        v1_sync, v2_sync;
    logic              edge_det;
    logic              running;
    logic              rearm_go;
`ifdef VCO_MEAS_CONT_EN
    logic              rearm;
    assign rearm_go = cont && rearm;
`else
    assign rearm_go = 1'b0;
`endif

    // Bits [1:0] are the synchronizer, bit 2 holds the previous synchronized level for edge detection.
    assign edge_det = sel ? (v2_sync[1] & ~v2_sync[2]) : (v1_sync[1] & ~v1_sync[2]);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ovf_nxt   = ovf;
        case (state)
            IDLE: begin
                if (start || rearm_go) state_nxt = SETTLE;
            end
            SETTLE: begin
                count_nxt = '0;
                ovf_nxt   = 1'b0;
                if (tmr == '0) state_nxt = (gate_q == '0) ? REPORT : GATE;
            end
            GATE: begin
                if (edge_det) begin
                    if (&count) ovf_nxt = 1'b1;
                    else        count_nxt = count + CNT_W'(1);
                end
                if (tmr == '0) state_nxt = REPORT;
            end
            REPORT: begin
                state_nxt = (mode_q == MODE_PAIR && !sel) ? SETTLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign running  = (state == SETTLE) || (state == GATE);
    assign busy     = (state != IDLE);
    assign done     = (state == REPORT);
    // Only the selected VCO is ever released, so both can never run together.
    assign vco1_rst = !(running && !sel);
    assign vco2_rst = !(running && sel);

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset that clears
    // every register, including the synchronizer flops and the reported result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            v1_sync    <= '0;
            v2_sync    <= '0;
            mode_q     <= '0;
            gate_q     <= '0;
            sel        <= 1'b0;
            tmr        <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            result     <= '0;
            result_sel <= 1'b0;
            overflow   <= 1'b0;
`ifdef VCO_MEAS_CONT_EN
            rearm      <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            v1_sync <= {v1_sync[1:0], vco1_in};
            v2_sync <= {v2_sync[1:0], vco2_in};
            count   <= count_nxt;
            ovf     <= ovf_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        gate_q <= gate_len;
                        sel    <= (mode == MODE_VCO2);
                        tmr    <= SETTLE_LOAD;
                    end else if (rearm_go) begin
                        sel <= (mode_q == MODE_VCO2);
                        tmr <= SETTLE_LOAD;
                    end
`ifdef VCO_MEAS_CONT_EN
                    rearm <= 1'b0;
`endif
                end
                SETTLE: begin
                    tmr <= (tmr == '0) ? TMR_W'(gate_q) - TMR_W'(1) : tmr - TMR_W'(1);
                end
                GATE: begin
                    tmr <= tmr - TMR_W'(1);
                end
                REPORT: begin
                    if (state_nxt == SETTLE) begin
                        sel <= 1'b1;
                        tmr <= SETTLE_LOAD;
                    end
`ifdef VCO_MEAS_CONT_EN
                    else begin
                        rearm <= 1'b1;
                    end
`endif
                end
                default: ;
            endcase
            // Result is loaded on entry to REPORT so it is already valid while done is high.
            if (state_nxt == REPORT) begin
                result     <= count_nxt;
                overflow   <= ovf_nxt;
                result_sel <= sel;
            end
        end
    end

endmodule
